// File: rtl/tank_move_sched_pkg.sv
// tank_pkg: shared definitions for the tank position scheduler and the renderer.
//   - dir_t       : 2-bit facing/move direction encoding
//   - POS_W/DIR_W : per-slot field widths of the packed position/direction buses
//   - X_MIN..Y_MAX: default playfield limits for the top-left corner of a tank
//   - pos_ext_t   : position widened by one bit for underflow-safe compares
//   - sched_state_t: scheduler FSM states
package tank_pkg;

  localparam int POS_W = 10;
  localparam int DIR_W = 2;

  localparam int X_MIN = 3;
  localparam int X_MAX = 609;
  localparam int Y_MIN = 1;
  localparam int Y_MAX = 449;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef logic [POS_W:0] pos_ext_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/tank_move_sched_step_clamp.sv
// tank_step_clamp: combinational single-step mover with playfield clamping.
// Ports:
//   x, y    : current position
//   dir     : requested direction
//   nx, ny  : next position (unchanged when the step is clamped)
//   blocked : high when the candidate position falls outside the limits
module tank_step_clamp #(
  parameter int STEP  = 1,
  parameter int X_MIN = tank_pkg::X_MIN,
  parameter int X_MAX = tank_pkg::X_MAX,
  parameter int Y_MIN = tank_pkg::Y_MIN,
  parameter int Y_MAX = tank_pkg::Y_MAX
) (
  input  logic [tank_pkg::POS_W-1:0] x,
  input  logic [tank_pkg::POS_W-1:0] y,
  input  tank_pkg::dir_t             dir,
  output logic [tank_pkg::POS_W-1:0] nx,
  output logic [tank_pkg::POS_W-1:0] ny,
  output logic                       blocked
);
  import tank_pkg::*;

  // One extra bit so that 0 - STEP wraps to a huge value and fails the
  // upper-bound check instead of sneaking past the lower one.
  localparam pos_ext_t STEP_C  = pos_ext_t'(STEP);
  localparam pos_ext_t X_MIN_C = pos_ext_t'(X_MIN);
  localparam pos_ext_t X_MAX_C = pos_ext_t'(X_MAX);
  localparam pos_ext_t Y_MIN_C = pos_ext_t'(Y_MIN);
  localparam pos_ext_t Y_MAX_C = pos_ext_t'(Y_MAX);

  pos_ext_t cand_s;

  // Candidate position on the move axis, accepted only inside the limits
  always_comb begin
    cand_s  = {(POS_W+1){1'b0}};
    nx      = x;
    ny      = y;
    blocked = 1'b0;
    case (dir)
      DIR_UP: begin
        cand_s = {1'b0, y} - STEP_C;
        if ((cand_s < Y_MIN_C) || (cand_s > Y_MAX_C)) blocked = 1'b1;
        else                                           ny = cand_s[POS_W-1:0];
      end
      DIR_DOWN: begin
        cand_s = {1'b0, y} + STEP_C;
        if ((cand_s < Y_MIN_C) || (cand_s > Y_MAX_C)) blocked = 1'b1;
        else                                           ny = cand_s[POS_W-1:0];
      end
      DIR_LEFT: begin
        cand_s = {1'b0, x} - STEP_C;
        if ((cand_s < X_MIN_C) || (cand_s > X_MAX_C)) blocked = 1'b1;
        else                                           nx = cand_s[POS_W-1:0];
      end
      DIR_RIGHT: begin
        cand_s = {1'b0, x} + STEP_C;
        if ((cand_s < X_MIN_C) || (cand_s > X_MAX_C)) blocked = 1'b1;
        else                                           nx = cand_s[POS_W-1:0];
      end
      default: begin
        nx      = x;
        ny      = y;
        blocked = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tank_move_sched.sv
// tank_move_sched: frame-synchronous round-robin move scheduler that owns the
// authoritative x/y/facing state of every tank slot.
// Ports:
//   clk_25m, rst       : pixel clock, async active-high reset
//   frame_tick         : once-per-frame start pulse (vertical blanking)
//   tank_exist         : slot enables
//   move_req, move_dir : per-slot request level and direction, snapshotted at frame_tick
//   tank_x, tank_y     : packed 10-bit positions, slot i at [10i+:10]
//   tank_dir           : packed 2-bit facing, slot i at [2i+:2]
//   gnt, blocked       : one-hot grant pulse and coincident clamp flag
//   busy, frame_done   : schedule in progress / completion pulse
//   overrun            : frame_tick seen while a schedule was still running
module tank_move_sched #(
  parameter int N_TANK  = 5,
  parameter int MAX_UPD = 5,
  parameter int STEP    = 1,
  parameter int X_MIN   = tank_pkg::X_MIN,
  parameter int X_MAX   = tank_pkg::X_MAX,
  parameter int Y_MIN   = tank_pkg::Y_MIN,
  parameter int Y_MAX   = tank_pkg::Y_MAX,
  parameter int INIT_X  = 3,
  parameter int INIT_Y  = 1
) (
  input  logic                                clk_25m,
  input  logic                                rst,
  input  logic                                frame_tick,
  input  logic [N_TANK-1:0]                   tank_exist,
  input  logic [N_TANK-1:0]                   move_req,
  input  logic [tank_pkg::DIR_W*N_TANK-1:0]   move_dir,
  output logic [tank_pkg::POS_W*N_TANK-1:0]   tank_x,
  output logic [tank_pkg::POS_W*N_TANK-1:0]   tank_y,
  output logic [tank_pkg::DIR_W*N_TANK-1:0]   tank_dir,
  output logic [N_TANK-1:0]                   gnt,
  output logic                                blocked,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                overrun
);
  import tank_pkg::*;

  localparam int IW = (N_TANK > 1) ? $clog2(N_TANK) : 1;
  localparam int CW = $clog2(MAX_UPD + 1);

  sched_state_t                        state_r, state_s;
  logic [N_TANK-1:0]                   pend_r, pend_s;
  logic [N_TANK-1:0][DIR_W-1:0]        dir_snap_r, dir_snap_s;
  logic [IW-1:0]                       idx_r, idx_s, idx_nxt_s, rr_ptr_r, rr_ptr_s;
  logic [CW-1:0]                       upd_cnt_r, upd_cnt_s;
  logic [N_TANK-1:0][POS_W-1:0]        x_r, x_s, y_r, y_s;
  logic [N_TANK-1:0][DIR_W-1:0]        dir_r, dir_s;
  logic [N_TANK-1:0]                   gnt_r, gnt_s;
  logic                                blocked_r, blocked_s;
  logic                                busy_r, busy_s;
  logic                                frame_done_r, frame_done_s;
  logic                                overrun_r, overrun_s;
  logic [POS_W-1:0]                    nx_s, ny_s;
  logic                                clamp_blk_s;

  assign idx_nxt_s = (idx_r == IW'(N_TANK - 1)) ? {IW{1'b0}} : idx_r + IW'(1);

  // Single shared datapath, steered to the slot currently being updated
  tank_step_clamp #(
    .STEP  (STEP),
    .X_MIN (X_MIN),
    .X_MAX (X_MAX),
    .Y_MIN (Y_MIN),
    .Y_MAX (Y_MAX)
  ) u_step_clamp (
    .x       (x_r[idx_r]),
    .y       (y_r[idx_r]),
    .dir     (dir_t'(dir_snap_r[idx_r])),
    .nx      (nx_s),
    .ny      (ny_s),
    .blocked (clamp_blk_s)
  );

  // Next-state and next-output logic of the scheduler
  always_comb begin
    state_s      = state_r;
    pend_s       = pend_r;
    dir_snap_s   = dir_snap_r;
    idx_s        = idx_r;
    upd_cnt_s    = upd_cnt_r;
    rr_ptr_s     = rr_ptr_r;
    x_s          = x_r;
    y_s          = y_r;
    dir_s        = dir_r;
    gnt_s        = {N_TANK{1'b0}};
    blocked_s    = 1'b0;
    busy_s       = busy_r;
    frame_done_s = 1'b0;
    overrun_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (frame_tick) begin
          pend_s     = move_req & tank_exist;
          dir_snap_s = move_dir;
          idx_s      = rr_ptr_r;
          upd_cnt_s  = {CW{1'b0}};
          busy_s     = 1'b1;
          state_s    = S_SCAN;
        end else begin
          busy_s  = 1'b0;
          state_s = S_IDLE;
        end
      end
      S_SCAN: begin
        overrun_s = frame_tick;
        if ((pend_r == {N_TANK{1'b0}}) || (upd_cnt_r == CW'(MAX_UPD))) begin
          state_s = S_DONE;
        end else if (pend_r[idx_r]) begin
          state_s = S_UPDATE;
        end else begin
          idx_s   = idx_nxt_s;
          state_s = S_SCAN;
        end
      end
      S_UPDATE: begin
        // A clamped move still turns the tank and still uses up budget
        overrun_s     = frame_tick;
        dir_s[idx_r]  = dir_snap_r[idx_r];
        x_s[idx_r]    = nx_s;
        y_s[idx_r]    = ny_s;
        blocked_s     = clamp_blk_s;
        gnt_s[idx_r]  = 1'b1;
        pend_s[idx_r] = 1'b0;
        upd_cnt_s     = upd_cnt_r + CW'(1);
        idx_s         = idx_nxt_s;
        state_s       = S_SCAN;
      end
      S_DONE: begin
        // Next frame resumes at the slot after the last one granted
        overrun_s    = frame_tick;
        rr_ptr_s     = idx_r;
        frame_done_s = 1'b1;
        busy_s       = 1'b0;
        state_s      = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      pend_r       <= {N_TANK{1'b0}};
      dir_snap_r   <= {(DIR_W*N_TANK){1'b0}};
      idx_r        <= {IW{1'b0}};
      upd_cnt_r    <= {CW{1'b0}};
      rr_ptr_r     <= {IW{1'b0}};
      x_r          <= {N_TANK{POS_W'(INIT_X)}};
      y_r          <= {N_TANK{POS_W'(INIT_Y)}};
      dir_r        <= {(DIR_W*N_TANK){1'b0}};
      gnt_r        <= {N_TANK{1'b0}};
      blocked_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      pend_r       <= pend_s;
      dir_snap_r   <= dir_snap_s;
      idx_r        <= idx_s;
      upd_cnt_r    <= upd_cnt_s;
      rr_ptr_r     <= rr_ptr_s;
      x_r          <= x_s;
      y_r          <= y_s;
      dir_r        <= dir_s;
      gnt_r        <= gnt_s;
      blocked_r    <= blocked_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      overrun_r    <= overrun_s;
    end
  end

  assign tank_x     = x_r;
  assign tank_y     = y_r;
  assign tank_dir   = dir_r;
  assign gnt        = gnt_r;
  assign blocked    = blocked_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_tank_move_sched.sv
// Directed self-checking bench for tank_move_sched. dut uses MAX_UPD=5,
// dut2 uses MAX_UPD=2; both share the same stimulus.
module tb_tank_move_sched;

  logic        clk_25m;
  logic        rst;
  logic        frame_tick;
  logic [4:0]  tank_exist;
  logic [4:0]  move_req;
  logic [9:0]  move_dir;

  logic [49:0] x1, y1, x2, y2;
  logic [9:0]  d1, d2;
  logic [4:0]  gnt1, gnt2;
  logic        blk1, blk2, busy1, busy2, fd1, fd2, ovr1, ovr2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] g1_q[$];
  logic [4:0] g2_q[$];
  int blk1_n, blk2_n, fd1_n, fd2_n, ovr1_n, first_g_k, fd_k;
  logic busy_k0, busy2_k0;

  tank_move_sched #(.MAX_UPD(5)) dut (
    .clk_25m(clk_25m), .rst(rst), .frame_tick(frame_tick),
    .tank_exist(tank_exist), .move_req(move_req), .move_dir(move_dir),
    .tank_x(x1), .tank_y(y1), .tank_dir(d1), .gnt(gnt1), .blocked(blk1),
    .busy(busy1), .frame_done(fd1), .overrun(ovr1)
  );

  tank_move_sched #(.MAX_UPD(2)) dut2 (
    .clk_25m(clk_25m), .rst(rst), .frame_tick(frame_tick),
    .tank_exist(tank_exist), .move_req(move_req), .move_dir(move_dir),
    .tank_x(x2), .tank_y(y2), .tank_dir(d2), .gnt(gnt2), .blocked(blk2),
    .busy(busy2), .frame_done(fd2), .overrun(ovr2)
  );

  initial clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  function automatic logic [49:0] rep10(input logic [9:0] v);
    logic [49:0] r;
    for (int i = 0; i < 5; i++) r[10*i +: 10] = v;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_25m);
    rst = 1'b1;
    frame_tick = 1'b0;
    repeat (2) @(negedge clk_25m);
    rst = 1'b0;
  endtask

  // One frame: tick, scramble the request inputs after the snapshot, then
  // record 16 cycles of outputs (longer than the worst-case schedule).
  task automatic run_frame(input logic [4:0] req, input logic [9:0] dir,
                           input logic [4:0] exist, input int extra_k);
    @(negedge clk_25m);
    tank_exist = exist;
    move_req   = req;
    move_dir   = dir;
    frame_tick = 1'b1;
    g1_q.delete();
    g2_q.delete();
    blk1_n = 0; blk2_n = 0; fd1_n = 0; fd2_n = 0; ovr1_n = 0;
    first_g_k = -1; fd_k = -1;
    @(negedge clk_25m);
    frame_tick = 1'b0;
    move_req   = ~req;
    move_dir   = ~dir;
    for (int k = 0; k < 16; k++) begin
      if (k != 0) @(negedge clk_25m);
      if (k == 0) begin
        busy_k0  = busy1;
        busy2_k0 = busy2;
      end
      if (gnt1 != 5'b0) begin
        g1_q.push_back(gnt1);
        if (first_g_k < 0) first_g_k = k;
      end
      if (gnt2 != 5'b0) g2_q.push_back(gnt2);
      if (blk1) blk1_n++;
      if (blk2) blk2_n++;
      if (fd1) begin
        fd1_n++;
        if (fd_k < 0) fd_k = k;
      end
      if (fd2) fd2_n++;
      if (ovr1) ovr1_n++;
      frame_tick = (k == extra_k) ? 1'b1 : 1'b0;
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    logic [49:0] ex;
    int tot_blk;
    int gcnt;
    rst = 1'b1;
    frame_tick = 1'b0;
    tank_exist = 5'b11111;
    move_req = 5'b0;
    move_dir = 10'b0;
    repeat (3) @(negedge clk_25m);
    rst = 1'b0;

    // Reset state
    check("rst_x", x1, rep10(10'd3));
    check("rst_y", y1, rep10(10'd1));
    check("rst_dir", d1, 10'd0);
    check("rst_ctl", {gnt1, blk1, busy1, fd1, ovr1}, 9'd0);

    // 1: single move right
    run_frame(5'b00001, 10'b00_00_00_00_11, 5'b11111, -1);
    check("t1_gnt_n", g1_q.size(), 1);
    check("t1_gnt", g1_q[0], 5'b00001);
    check("t1_gnt_lat", (first_g_k >= 0) && (first_g_k <= 2), 1'b1);
    check("t1_done_lat", (fd_k >= 0) && (fd_k <= 4), 1'b1);
    check("t1_done_n", fd1_n, 1);
    check("t1_x", x1, {rep10(10'd3)} + 50'd1);
    check("t1_blk", blk1_n, 0);
    check("t1_busy0", busy_k0, 1'b1);
    check("t1_busy_end", busy1, 1'b0);

    // 2: clamps at left edge, top edge, then bottom edge
    do_reset();
    run_frame(5'b00001, 10'd2, 5'b11111, -1);
    check("t2_left_gnt", g1_q.size(), 1);
    check("t2_left_blk", blk1_n, 1);
    check("t2_left_x", x1, rep10(10'd3));
    check("t2_left_dir", d1, 10'd2);
    run_frame(5'b00001, 10'd0, 5'b11111, -1);
    check("t2_up_blk", blk1_n, 1);
    check("t2_up_y", y1, rep10(10'd1));
    check("t2_up_dir", d1, 10'd0);
    tot_blk = 0;
    for (int f = 0; f < 448; f++) begin
      run_frame(5'b00001, 10'd1, 5'b11111, -1);
      tot_blk += blk1_n;
    end
    ex = rep10(10'd1);
    ex[9:0] = 10'd449;
    check("t2_walk_y", y1, ex);
    check("t2_walk_blk", tot_blk, 0);
    run_frame(5'b00001, 10'd1, 5'b11111, -1);
    check("t2_down_blk", blk1_n, 1);
    check("t2_down_y", y1, ex);
    check("t2_down_dir", d1, 10'd1);
    run_frame(5'b00001, 10'd0, 5'b11111, -1);
    ex[9:0] = 10'd448;
    check("t2_back_y", y1, ex);
    check("t2_back_blk", blk1_n, 0);

    // 3: MAX_UPD=2 rotation on dut2, full service on dut
    do_reset();
    run_frame(5'b11111, 10'h3FF, 5'b11111, -1);
    check("t3_f1_n", g2_q.size(), 2);
    check("t3_f1_g", {g2_q[0], g2_q[1]}, {5'b00001, 5'b00010});
    check("t3_f1_done", fd2_n, 1);
    check("t3_full_n", g1_q.size(), 5);
    check("t3_full_g", {g1_q[0], g1_q[1], g1_q[2], g1_q[3], g1_q[4]},
          {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000});
    run_frame(5'b11111, 10'h3FF, 5'b11111, -1);
    check("t3_f2_n", g2_q.size(), 2);
    check("t3_f2_g", {g2_q[0], g2_q[1]}, {5'b00100, 5'b01000});
    check("t3_f2_done", fd2_n, 1);
    run_frame(5'b11111, 10'h3FF, 5'b11111, -1);
    check("t3_f3_n", g2_q.size(), 2);
    check("t3_f3_g", {g2_q[0], g2_q[1]}, {5'b10000, 5'b00001});
    check("t3_f3_done", fd2_n, 1);
    ex = rep10(10'd4);
    ex[9:0] = 10'd5;
    check("t3_x2", x2, ex);
    check("t3_x1", x1, rep10(10'd6));
    check("t3_d2", d2, 10'h3FF);

    // 4: disabled slot 0 is skipped
    do_reset();
    run_frame(5'b11111, 10'h3FF, 5'b11110, -1);
    check("t4_n", g1_q.size(), 4);
    check("t4_g", {g1_q[0], g1_q[1], g1_q[2], g1_q[3]},
          {5'b00010, 5'b00100, 5'b01000, 5'b10000});
    ex = rep10(10'd4);
    ex[9:0] = 10'd3;
    check("t4_x", x1, ex);

    // 5: second tick while busy
    do_reset();
    run_frame(5'b11111, 10'h3FF, 5'b11111, 1);
    check("t5_ovr", ovr1_n, 1);
    check("t5_n", g1_q.size(), 5);
    check("t5_done", fd1_n, 1);
    check("t5_x", x1, rep10(10'd4));

    // 6: reset between 2nd and 3rd grant
    do_reset();
    @(negedge clk_25m);
    tank_exist = 5'b11111;
    move_req   = 5'b11111;
    move_dir   = 10'h3FF;
    frame_tick = 1'b1;
    @(negedge clk_25m);
    frame_tick = 1'b0;
    gcnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (gcnt < 2) begin
        if (k != 0) @(negedge clk_25m);
        if (gnt1 != 5'b0) gcnt++;
      end
    end
    check("t6_two_gnts", gcnt, 2);
    rst = 1'b1;
    #1;
    check("t6_x", x1, rep10(10'd3));
    check("t6_y", y1, rep10(10'd1));
    check("t6_dir", d1, 10'd0);
    check("t6_ctl", {gnt1, blk1, busy1, fd1, ovr1}, 9'd0);
    @(negedge clk_25m);
    rst = 1'b0;
    run_frame(5'b11111, 10'h3FF, 5'b11111, -1);
    check("t6_restart_g", g1_q[0], 5'b00001);
    check("t6_restart_n", g1_q.size(), 5);
    check("t6_restart_x", x1, rep10(10'd4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
